// File: rtl/thermocouple_pkg.sv
// Shared definitions for the thermocouple responder.
//   FRAME_W and the bit positions of the 32-bit read-out frame, the
//   serializer state enum, a debug snapshot struct and a frame packer.
package thermocouple_pkg;

  localparam int FRAME_W = 32;
  localparam int TC_W    = 14;
  localparam int JT_W    = 12;
  localparam int FLT_W   = 4;

  // Frame bit positions
  localparam int TC_LSB        = 18;  // [31:18] thermocouple temperature
  localparam int RSV_HI_BIT    = 17;  // always 0
  localparam int FAULT_ANY_BIT = 16;  // summary fault flag
  localparam int JT_LSB        = 4;   // [15:4] cold-junction temperature
  localparam int RSV_LO_BIT    = 3;   // always 0
  localparam int FLT_LSB       = 0;   // [2:0] SCV / SCG / OC

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2
  } ser_state_t;

  // Internal visibility for checkers: FSM state and synchronized pins.
  typedef struct packed {
    ser_state_t  state;
    logic [4:0]  bit_cnt;
    logic        cs_sync;
    logic        sck_sync;
    logic        sck_rise;
  } ser_dbg_t;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [TC_W-1:0]  tc,
    input logic [JT_W-1:0]  jt,
    input logic [FLT_W-1:0] flt
  );
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[TC_LSB +: TC_W]    = tc;
    f[RSV_HI_BIT]        = 1'b0;
    // Forced fault or any individual fault raises the summary flag.
    f[FAULT_ANY_BIT]     = |flt;
    f[JT_LSB +: JT_W]    = jt;
    f[RSV_LO_BIT]        = 1'b0;
    f[FLT_LSB +: 3]      = flt[2:0];
    return f;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with rise/fall pulse outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   sync       : synchronized level (after STAGES flops)
//   rise, fall : one-cycle pulses on synchronized transitions
// IDLE_LEVEL is the level the chain resets to, so reset never fabricates an edge
// while the pin sits at its idle level.
module sync_edge_detect #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{IDLE_LEVEL}};
      prev  <= IDLE_LEVEL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/thermocouple_responder.sv
// Thermocouple-to-digital converter emulator with an SPI mode-0 read-out.
//   clk, rst_n          : clock, asynchronous active-low reset
//   tc_temp_data[13:0]  : thermocouple temperature (0.25 C/LSB)
//   junction_temp_data  : cold-junction temperature (0.0625 C/LSB)
//   fault_bits[3:0]     : [3] forced, [2] SCV, [1] SCG, [0] OC
//   cs_n, sck           : SPI pins, asynchronous to clk
//   miso, miso_oe       : serial data out (MSB first) and its output enable
//   frame_done          : one-cycle pulse after a complete 32-bit frame
//   sample_valid        : a conversion has completed since reset
//   dbg                 : FSM state and synchronized pin snapshot
// Handshake: there is no valid/ready pair; a frame is a cs_n low window, bits
// change after each synchronized sck falling edge and frame_done marks that
// all 32 bits were shifted.
module thermocouple_responder
  import thermocouple_pkg::*;
#(
  parameter int CONV_CYCLES = 600,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TC_W-1:0]   tc_temp_data,
  input  logic [JT_W-1:0]   junction_temp_data,
  input  logic [FLT_W-1:0]  fault_bits,
  input  logic              cs_n,
  input  logic              sck,
  output logic              miso,
  output logic              miso_oe,
  output logic              frame_done,
  output logic              sample_valid,
  output ser_dbg_t          dbg
);

  localparam int                CNT_W    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CONV_CYCLES - 1);

  logic cs_sync, cs_rise, cs_fall;
  logic sck_sync, sck_rise, sck_fall;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (cs_n),
    .sync (cs_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sck),
    .sync (sck_sync),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // Conversion emulation: runs only while deselected so a frame in flight
  // always sees a stable sample register.
  logic [CNT_W-1:0]   conv_cnt;
  logic [FRAME_W-1:0] sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_cnt     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else if (cs_sync) begin
      if (conv_cnt == CNT_LAST) begin
        conv_cnt     <= '0;
        sample       <= pack_frame(tc_temp_data, junction_temp_data, fault_bits);
        sample_valid <= 1'b1;
      end else begin
        conv_cnt <= conv_cnt + CNT_W'(1);
      end
    end
  end

  // Serializer FSM
  ser_state_t         state, state_next;
  logic [FRAME_W-1:0] shift_reg;
  logic [4:0]         bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (cs_fall) state_next = ST_SHIFT;
      // Deselect before bit 0 is consumed is an abort: straight back to idle.
      ST_SHIFT: if (cs_rise)                        state_next = ST_IDLE;
                else if (sck_fall && bit_cnt == '0) state_next = ST_TAIL;
      ST_TAIL:  if (cs_rise) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath. A load can only happen from IDLE, where sck edges are ignored,
  // so a coincident sck falling edge never shifts the freshly loaded word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == ST_SHIFT) && (state_next == ST_TAIL);
      if (state == ST_IDLE && cs_fall) begin
        shift_reg <= sample;
        bit_cnt   <= 5'd31;
      end else if (state == ST_SHIFT && !cs_rise && sck_fall && bit_cnt != '0) begin
        shift_reg <= shift_reg << 1;
        bit_cnt   <= bit_cnt - 5'd1;
      end
    end
  end

  always_comb begin
    miso    = 1'b0;
    miso_oe = ~cs_sync;
    if (state == ST_SHIFT) miso = shift_reg[FRAME_W-1];
  end

  always_comb begin
    dbg.state    = state;
    dbg.bit_cnt  = bit_cnt;
    dbg.cs_sync  = cs_sync;
    dbg.sck_sync = sck_sync;
    dbg.sck_rise = sck_rise;
  end

endmodule

// File: doc/thermocouple_responder.md
THERMOCOUPLE_RESPONDER -- requirements
Module: thermocouple_responder

Interface
REQ-001 Parameter CONV_CYCLES, default 600: clk cycles per emulated conversion.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for cs_n and sck.
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port tc_temp_data, input, 14: thermocouple temperature, two's complement, 0.25 C/LSB.
REQ-006 Port junction_temp_data, input, 12: cold-junction temperature, two's complement, 0.0625 C/LSB.
REQ-007 Port fault_bits, input, 4: [3] forced fault, [2] SCV, [1] SCG, [0] OC.
REQ-008 Port cs_n, input, 1: SPI chip select, active-low, asynchronous to clk.
REQ-009 Port sck, input, 1: SPI clock, mode 0 (CPOL=0), asynchronous to clk.
REQ-010 Port miso, output, 1: serial data out, MSB first.
REQ-011 Port miso_oe, output, 1: high while synchronized cs_n is low.
REQ-012 Port frame_done, output, 1: one-cycle pulse after a complete 32-bit frame.
REQ-013 Port sample_valid, output, 1: high once the first conversion has completed since reset.

Function
REQ-014 Frame layout: [31:18]=tc_temp_data, [17]=0, [16]=fault_bits[3] OR any of fault_bits[2:0], [15:4]=junction_temp_data, [3]=0, [2:0]=fault_bits[2:0].
REQ-015 Conversion counter counts 0..CONV_CYCLES-1 while synchronized cs_n is high; at terminal count it loads the frame into the sample register, sets sample_valid, and wraps to 0.
REQ-016 While synchronized cs_n is low, the conversion counter holds, and the sample register does not update.
REQ-017 cs_n and sck pass through SYNC_STAGES flops each; edges are detected on synchronized values only.
REQ-018 Serializer FSM states: IDLE, SHIFT, TAIL.
REQ-019 IDLE -> SHIFT on synchronized cs_n falling edge: shift register loads from the sample register, bit counter = 31, miso = sample[31] in the same cycle.
REQ-020 In SHIFT, each synchronized sck falling edge shifts left and drives the next bit; rising edges change nothing.
REQ-021 After the 32nd sck falling edge (bit 0 consumed), FSM -> TAIL and pulses frame_done for exactly one cycle.
REQ-022 In TAIL, miso = 0 for any further sck edges.
REQ-023 Any state -> IDLE on synchronized cs_n rising edge; miso = 0 in IDLE.
REQ-024 cs_n rising edge in SHIFT is an abort: no frame_done, and the sample register is unaffected.
REQ-025 cs_n falling and sck falling edges detected in the same cycle: the load takes priority and the sck edge is ignored.
REQ-026 miso updates within SYNC_STAGES+1 clk of a pin-level sck falling edge; supported sck half-period is >= SYNC_STAGES+2 clk.
REQ-027 A frame read before sample_valid shifts out all zeros.

Reset
REQ-028 rst_n low asynchronously forces: miso=0, miso_oe=0, frame_done=0, sample_valid=0, FSM=IDLE, sample register=0, counters=0, synchronizer flops=idle level (cs_n=1, sck=0).
REQ-029 Reset asserted mid-frame abandons the frame; after release the block waits for a new cs_n falling edge.

Structure
REQ-030 Shared package thermocouple_pkg holds FRAME_W=32, the bit-position constants of REQ-014, and the serializer state enum.
REQ-031 One sub-module, sync_edge_detect (SYNC_STAGES flops plus a rise/fall pulse pair), is instantiated once for cs_n and once for sck.

Verification
REQ-032 Inputs tc=14'h0190, jt=12'h190, faults=0; wait > CONV_CYCLES; read 32 bits -> 0x06401900, then frame_done pulses once.
REQ-033 Same temperatures, faults=4'b0001 -> frame 0x06411901 (bit16 and bit0 set).
REQ-034 Read immediately after reset release (before CONV_CYCLES) -> 0x00000000 and sample_valid=0.
REQ-035 Raise cs_n after 10 sck edges -> no frame_done; next full read returns the correct frame.
REQ-036 Change inputs during a frame -> the current frame is unchanged; the new values appear only after cs_n high for CONV_CYCLES.
REQ-037 Assert rst_n low at bit 16 -> miso=0 and miso_oe=0 immediately; next frame after release is correct.
